// File: rtl/collision_update_arbiter_if.sv
// Velocity register-file write port: valid/ready handshake carrying requester index and new X/Y velocity.
// The master side is the arbiter, the slave side is the velocity register file.
interface collision_update_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned VEL_W   = 11
);
    localparam int unsigned IdxW = $clog2(NUM_REQ);

    logic            wrValid;
    logic            wrReady;
    logic [IdxW-1:0] wrIdx;
    logic [VEL_W-1:0] wrVelX;
    logic [VEL_W-1:0] wrVelY;

    modport master (
        output wrValid,
        output wrIdx,
        output wrVelX,
        output wrVelY,
        input  wrReady
    );

    modport slave (
        input  wrValid,
        input  wrIdx,
        input  wrVelX,
        input  wrVelY,
        output wrReady
    );
endinterface

// File: rtl/collision_update_arbiter.sv
// Round-robin arbiter sharing the velocity write port between NUM_REQ collision detectors.
// Optional per-frame handshake counter is built only when COLLISION_HIT_COUNT_EN is defined.
module collision_update_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned VEL_W   = 11
) (
    input  logic                     clk,
    input  logic                     resetN,
    input  logic                     startOfFrame,
    input  logic [NUM_REQ-1:0]       reqIn,
    input  logic [NUM_REQ*VEL_W-1:0] reqVelX,
    input  logic [NUM_REQ*VEL_W-1:0] reqVelY,
    collision_update_arbiter_if.master wr,
    output logic                     droppedEvent,
    output logic                     busy,
    output logic [7:0]               hitCount
);
    localparam int unsigned IdxW = $clog2(NUM_REQ);

    typedef enum logic [0:0] {StIdle, StIssue} state_e;

    state_e              state_q, state_d;
    logic [NUM_REQ-1:0]  pending_q, pending_d;
    logic [NUM_REQ-1:0]  armed_q, armed_d;
    logic [VEL_W-1:0]    vel_x_q [NUM_REQ];
    logic [VEL_W-1:0]    vel_x_d [NUM_REQ];
    logic [VEL_W-1:0]    vel_y_q [NUM_REQ];
    logic [VEL_W-1:0]    vel_y_d [NUM_REQ];
    logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
    logic                wr_valid_q, wr_valid_d;
    logic [IdxW-1:0]     wr_idx_q, wr_idx_d;
    logic [VEL_W-1:0]    wr_vel_x_q, wr_vel_x_d;
    logic [VEL_W-1:0]    wr_vel_y_q, wr_vel_y_d;
    logic                dropped_q, dropped_d;
    logic                found;
    logic [IdxW-1:0]     sel_idx;
    logic                handshake;
    logic                slot_free;

    assign handshake = (state_q == StIssue) && wr.wrReady;

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        armed_d    = armed_q;
        vel_x_d    = vel_x_q;
        vel_y_d    = vel_y_q;
        rr_ptr_d   = rr_ptr_q;
        wr_valid_d = wr_valid_q;
        wr_idx_d   = wr_idx_q;
        wr_vel_x_d = wr_vel_x_q;
        wr_vel_y_d = wr_vel_y_q;
        dropped_d  = 1'b0;
        found      = 1'b0;
        sel_idx    = '0;
        slot_free  = 1'b0;

        // First pending slot at or after rr_ptr, cyclic.
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            if (!found && pending_q[(int'(rr_ptr_q) + k) % int'(NUM_REQ)]) begin
                found   = 1'b1;
                sel_idx = IdxW'((int'(rr_ptr_q) + k) % int'(NUM_REQ));
            end
        end

        unique case (state_q)
            StIdle: begin
                if (found && !startOfFrame) begin
                    state_d    = StIssue;
                    wr_valid_d = 1'b1;
                    wr_idx_d   = sel_idx;
                    wr_vel_x_d = vel_x_q[sel_idx];
                    wr_vel_y_d = vel_y_q[sel_idx];
                end
            end
            StIssue: begin
                if (handshake) begin
                    state_d             = StIdle;
                    wr_valid_d          = 1'b0;
                    pending_d[wr_idx_q] = 1'b0;
                    rr_ptr_d = (wr_idx_q == IdxW'(NUM_REQ - 1)) ? '0 : wr_idx_q + IdxW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (startOfFrame) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (!(state_q == StIssue && wr_idx_q == IdxW'(i))) pending_d[i] = 1'b0;
            end
        end

        // Capture runs last so it overrides both the handshake clear and the frame flush.
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            slot_free = !pending_q[i] || (handshake && wr_idx_q == IdxW'(i));
            if (!reqIn[i]) begin
                armed_d[i] = 1'b1;
            end else if (armed_q[i]) begin
                armed_d[i] = 1'b0;
                if (slot_free) begin
                    pending_d[i] = 1'b1;
                    vel_x_d[i]   = reqVelX[i*VEL_W +: VEL_W];
                    vel_y_d[i]   = reqVelY[i*VEL_W +: VEL_W];
                end else begin
                    dropped_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= StIdle;
            pending_q  <= '0;
            armed_q    <= '1;
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                vel_x_q[i] <= '0;
                vel_y_q[i] <= '0;
            end
            rr_ptr_q   <= '0;
            wr_valid_q <= 1'b0;
            wr_idx_q   <= '0;
            wr_vel_x_q <= '0;
            wr_vel_y_q <= '0;
            dropped_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            armed_q    <= armed_d;
            vel_x_q    <= vel_x_d;
            vel_y_q    <= vel_y_d;
            rr_ptr_q   <= rr_ptr_d;
            wr_valid_q <= wr_valid_d;
            wr_idx_q   <= wr_idx_d;
            wr_vel_x_q <= wr_vel_x_d;
            wr_vel_y_q <= wr_vel_y_d;
            dropped_q  <= dropped_d;
        end
    end

`ifdef COLLISION_HIT_COUNT_EN
    logic [7:0] hit_count_q, hit_count_d;

    always_comb begin
        hit_count_d = hit_count_q;
        if (startOfFrame) begin
            hit_count_d = handshake ? 8'd1 : 8'd0;
        end else if (handshake && hit_count_q != 8'hFF) begin
            hit_count_d = hit_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) hit_count_q <= 8'd0;
        else         hit_count_q <= hit_count_d;
    end

    assign hitCount = hit_count_q;
`else
    assign hitCount = 8'd0;
`endif

    assign wr.wrValid    = wr_valid_q;
    assign wr.wrIdx      = wr_idx_q;
    assign wr.wrVelX     = wr_vel_x_q;
    assign wr.wrVelY     = wr_vel_y_q;
    assign droppedEvent  = dropped_q;
    assign busy          = (state_q != StIdle) || (|pending_q);
endmodule
